// File: rtl/rv32_pkg.sv
// Shared RV32 fetch types: exception codes, fetch FSM states, the canonical NOP
// and the fetch-address fault check.
package rv32_pkg;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    MISALIGNED   = 2'd1,
    ACCESS_FAULT = 2'd2
  } fetch_exc_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Misalignment wins over range; last_word is the highest legal word address.
  function automatic fetch_exc_e fetch_exc(input logic [31:0] pc,
                                           input logic [31:0] last_word);
    if (pc[1:0] != 2'b00) return MISALIGNED;
    if (pc > last_word)   return ACCESS_FAULT;
    return NONE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: combinational instruction-source port, redirect input from
// execute, and the IF/ID valid/ready slot toward decode.
interface fetch_stage_if;
  import rv32_pkg::*;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  fetch_exc_e  id_exc;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_instr,
    output id_pc_plus4,
    output id_exc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_instr,
    input  id_pc_plus4,
    input  id_exc
  );

endinterface

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC register, next-PC mux, fault check and a
// single IF/ID slot, sequenced by a BOOT/RUN/HALT FSM with redirect flush.
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  logic         slot_valid_q;
  logic [31:0]  slot_pc_q;
  logic [31:0]  slot_pc4_q;
  logic [31:0]  slot_instr_q;
  fetch_exc_e   slot_exc_q;

  fetch_exc_e   pc_exc;
  logic         slot_free;
  logic         issue;
  logic         flush;

  assign pc_exc    = fetch_exc(pc_q, LAST_WORD);
  assign slot_free = !slot_valid_q || bus.id_ready;

  // Redirect outranks everything; BOOT only spends one cycle letting the
  // instruction source settle, so it may take a redirect but never issues.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
      end
      RUN, HALT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = RUN;
          flush   = 1'b1;
        end else if (state_q == RUN && slot_free) begin
          issue = 1'b1;
          if (pc_exc != NONE) state_d = HALT;
          else                pc_d    = pc_q + 32'd4;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A flush discards the held entry even if decode is accepting it this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      slot_pc_q    <= '0;
      slot_pc4_q   <= '0;
      slot_instr_q <= '0;
      slot_exc_q   <= NONE;
    end else if (flush) begin
      slot_valid_q <= 1'b0;
    end else if (issue) begin
      slot_valid_q <= 1'b1;
      slot_pc_q    <= pc_q;
      slot_pc4_q   <= pc_q + 32'd4;
      slot_instr_q <= (pc_exc == NONE) ? bus.imem_instr : NOP_INSTR;
      slot_exc_q   <= pc_exc;
    end else if (bus.id_ready) begin
      slot_valid_q <= 1'b0;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = slot_valid_q;
  assign bus.id_pc       = slot_pc_q;
  assign bus.id_pc_plus4 = slot_pc4_q;
  assign bus.id_instr    = slot_instr_q;
  assign bus.id_exc      = slot_exc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID entries are queued as
// stimulus is applied and compared as decode consumes them.
module tb_fetch_stage;
  import rv32_pkg::*;

  localparam int unsigned IMEM_BYTES = 256;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    fetch_exc_e  exc;
  } exp_t;

  logic clk;
  logic rst_n;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction source: addi x1,x0,i at word i (word 0 is a NOP); out of range reads junk.
  function automatic logic [31:0] imem_word(input logic [29:0] idx);
    if (idx >= 30'(IMEM_BYTES / 4)) return 32'hFFFF_FFFF;
    if (idx == 30'd0) return 32'h0000_0013;
    return 32'h0000_0093 | ({2'b00, idx} << 20);
  endfunction

  always_comb bus.imem_instr = imem_word(bus.imem_addr[31:2]);

  function automatic exp_t model_entry(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    if (pc[1:0] != 2'b00)                 e.exc = MISALIGNED;
    else if (pc > 32'(IMEM_BYTES - 4))    e.exc = ACCESS_FAULT;
    else                                  e.exc = NONE;
    e.instr = (e.exc == NONE) ? imem_word(pc[31:2]) : 32'h0000_0013;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) sb.push_back(model_entry(pc + 32'(4 * i)));
  endtask

  // Consumption monitor: an entry leaves the slot only on valid&ready without redirect.
  always @(negedge clk) begin
    if (rst_n && bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("id_pc", bus.id_pc, e.pc);
        check("id_instr", bus.id_instr, e.instr);
        check("id_exc", 32'(bus.id_exc), 32'(e.exc));
        check("id_pc_plus4", bus.id_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  // Redirect, expect the flush bubble, then let n entries from pc be consumed.
  task automatic redirect_to(input logic [31:0] pc, input int n);
    push_run(pc, n);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    check("flush_valid", 32'(bus.id_valid), 32'd0);
    check("flush_addr", bus.imem_addr, pc);
    tick();
    check("redir_first_valid", 32'(bus.id_valid), 32'd1);
    check("redir_first_pc", bus.id_pc, pc);
    repeat (n) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    repeat (2) tick();

    check("rst_valid", 32'(bus.id_valid), 32'd0);
    check("rst_pc", bus.id_pc, 32'd0);
    check("rst_instr", bus.id_instr, 32'd0);
    check("rst_pc4", bus.id_pc_plus4, 32'd0);
    check("rst_exc", 32'(bus.id_exc), 32'(NONE));
    check("rst_addr", bus.imem_addr, RESET_PC);

    // Boot stream, then backpressure at pc 8.
    push_run(32'h0, 5);
    rst_n = 1'b1;
    tick();
    check("boot_no_issue", 32'(bus.id_valid), 32'd0);
    tick();
    check("first_valid", 32'(bus.id_valid), 32'd1);
    check("first_pc", bus.id_pc, 32'h0);
    tick();
    check("second_pc", bus.id_pc, 32'h4);
    tick();
    check("third_pc", bus.id_pc, 32'h8);
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(bus.id_valid), 32'd1);
      check("stall_pc", bus.id_pc, 32'h8);
      check("stall_instr", bus.id_instr, imem_word(30'd2));
      check("stall_addr", bus.imem_addr, 32'hC);
    end
    bus.id_ready = 1'b1;
    tick();
    check("resume_pc", bus.id_pc, 32'hC);
    tick();
    tick();
    check("pre_redirect_pc", bus.id_pc, 32'h14);

    // Redirect while an entry is being accepted: pc 0x14 is discarded.
    redirect_to(32'h40, 2);

    // Redirect while decode is stalled.
    bus.id_ready = 1'b0;
    tick();
    check("stall2_pc", bus.id_pc, 32'h48);
    redirect_to(32'h80, 2);

    // Misaligned redirect: faulting entry, then HALT until the next redirect.
    sb.push_back(model_entry(32'h42));
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    tick();
    bus.redirect_valid = 1'b0;
    check("mis_flush", 32'(bus.id_valid), 32'd0);
    tick();
    check("mis_pc", bus.id_pc, 32'h42);
    check("mis_exc", 32'(bus.id_exc), 32'(MISALIGNED));
    check("mis_instr", bus.id_instr, NOP_INSTR);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_valid", 32'(bus.id_valid), 32'd0);
      check("halt_addr", bus.imem_addr, 32'h42);
    end
    redirect_to(32'h10, 3);

    // Run off the end of the instruction source.
    redirect_to(32'hF0, 4);
    sb.push_back(model_entry(32'h100));
    check("af_pc", bus.id_pc, 32'h100);
    check("af_exc", 32'(bus.id_exc), 32'(ACCESS_FAULT));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("af_halt_valid", 32'(bus.id_valid), 32'd0);
      check("af_halt_addr", bus.imem_addr, 32'h100);
    end
    check("af_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-stream, between clock edges.
    redirect_to(32'h20, 2);
    check("pre_rst_valid", 32'(bus.id_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.id_valid), 32'd0);
    check("async_rst_addr", bus.imem_addr, RESET_PC);
    check("async_rst_pc", bus.id_pc, 32'd0);
    tick();
    push_run(32'h0, 2);
    rst_n = 1'b1;
    tick();
    check("reboot_no_issue", 32'(bus.id_valid), 32'd0);
    tick();
    check("reboot_pc", bus.id_pc, 32'h0);
    tick();
    tick();
    check("reboot_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
